rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter AGE_LIMIT, default 4, meaning: consecutive stalled cycles of req1 before forced grant (fixed-priority mode only, legal range 1..7).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-005 req0_addr  input  5  requester 0 destination register.
REQ-006 req0_data  input  32  requester 0 write data.
REQ-007 req0_ready  output  1  requester 0 write accepted this cycle.
REQ-008 req1_valid / req1_addr / req1_data / req1_ready  as REQ-004..007, requester 1 (load/multi-cycle unit).
REQ-009 rf_we  output  1  register file write enable.
REQ-010 rf_a3  output  5  register file write address.
REQ-011 rf_wd3  output  32  register file write data.
REQ-012 pend_mask  output  32  one-hot of rf_a3 when rf_we=1, else all zero; consumed by the hazard unit.

Function
REQ-013 Transfer on reqN: reqN_valid=1 and reqN_ready=1 in the same cycle.
REQ-014 reqN_ready is combinational from arbitration; it is never 1 while reqN_valid=0.
REQ-015 At most one of req0_ready/req1_ready is 1 per cycle.
REQ-016 Only one requester valid: it is granted in that cycle, no bubble.
REQ-017 Requester not granted holds valid, addr and data stable until ready; arbiter does not require retraction.
REQ-018 Output stage is registered: accepted write appears on rf_we/rf_a3/rf_wd3 exactly 1 cycle after transfer.
REQ-019 Transfer with addr=0: accepted (ready=1) but rf_we=0 next cycle; rf_a3/rf_wd3 hold previous values.
REQ-020 No transfer in a cycle: rf_we=0 next cycle; rf_a3/rf_wd3 hold.
REQ-021 Both valid, same address: arbitration unchanged; both writes issue in grant order, last writer wins in the register file.
REQ-022 Round-robin mode: last_grant register (1 bit); both valid -> grant the requester not equal to last_grant; last_grant updates on every transfer.
REQ-023 Fixed-priority mode: both valid -> req0 wins unless age >= AGE_LIMIT, then req1 wins.
REQ-024 age: 3-bit counter; +1 each cycle req1_valid=1 and req1_ready=0 (saturates at 7); cleared on req1 transfer or req1_valid=0.
REQ-025 Throughput: one transfer per cycle sustained; output stage never back-pressures.

Reset
REQ-026 rst_n low: rf_we=0, rf_a3=0, rf_wd3=0, pend_mask=0, last_grant=1, age=0, immediately without clock.
REQ-027 While rst_n low: req0_ready=0, req1_ready=0; no transfers.
REQ-028 Reset mid-operation: a write registered but not yet issued is dropped; first transfer possible in the first cycle after rst_n rises.

Configuration
REQ-029 Macro WB_ARB_RR_EN defined: round-robin per REQ-022; age counter absent; AGE_LIMIT ignored.
REQ-030 WB_ARB_RR_EN undefined: fixed priority with aging per REQ-023/024; last_grant absent.

Verification
REQ-031 Reset: rst_n low mid-write with req0 addr=5 pending -> rf_we=0, pend_mask=0 asynchronously, no write to x5 after release.
REQ-032 Single: req0 addr=3 data=0xDEADBEEF one cycle -> req0_ready=1 same cycle; next cycle rf_we=1, rf_a3=3, rf_wd3=0xDEADBEEF, pend_mask=0x00000008.
REQ-033 x0: req1 addr=0 data=0x1234 -> req1_ready=1; next cycle rf_we=0, pend_mask=0.
REQ-034 RR (WB_ARB_RR_EN): both valid continuously from reset, addrs 1/2 -> grants req0,req1,req0,req1; rf_a3 sequence 1,2,1,2.
REQ-035 Fixed (AGE_LIMIT=4): both valid continuously -> req0 granted 4 cycles, req1 granted cycle 5, age cleared, req0 granted cycle 6.
REQ-036 Collision: both valid addr=7, req0 data=0xA, req1 data=0xB, RR from reset -> rf_wd3 0xA then 0xB on consecutive cycles, x7 finally holds 0xB.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register file.
// The arbiter uses the slave modport; the requester/RF side uses master.
interface rf_wb_arbiter_if;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic [31:0] pend_mask;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_we, rf_a3, rf_wd3, pend_mask
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_we, rf_a3, rf_wd3, pend_mask
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter with a registered write stage.
// WB_ARB_RR_EN selects round-robin; otherwise fixed priority (req0) with req1 aging.
module rf_wb_arbiter #(
  parameter int AGE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  rf_wb_arbiter_if.slave bus
);
  logic        gnt0, gnt1, xfer;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_a3_q, rf_a3_d;
  logic [31:0] rf_wd3_q, rf_wd3_d;

`ifdef WB_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // Contention goes to whichever requester did not win the last transfer.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt1)      last_grant_d = 1'b1;
    else if (gnt0) last_grant_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`else
  localparam logic [2:0] AGE_LIM = 3'(AGE_LIMIT);
  logic [2:0] age_q, age_d;

  // req0 wins contention until req1 has been starved AGE_LIMIT cycles.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt1 = (age_q >= AGE_LIM);
        gnt0 = !gnt1;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  always_comb begin
    age_d = age_q;
    if (!bus.req1_valid || gnt1) age_d = 3'd0;
    else if (age_q != 3'd7)      age_d = age_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) age_q <= 3'd0;
    else        age_q <= age_d;
  end
`endif

  assign xfer     = gnt0 || gnt1;
  assign sel_addr = gnt1 ? bus.req1_addr : bus.req0_addr;
  assign sel_data = gnt1 ? bus.req1_data : bus.req0_data;

  // Writes to x0 are accepted but dropped; address/data hold their last value.
  always_comb begin
    rf_we_d  = 1'b0;
    rf_a3_d  = rf_a3_q;
    rf_wd3_d = rf_wd3_q;
    if (xfer && sel_addr != 5'd0) begin
      rf_we_d  = 1'b1;
      rf_a3_d  = sel_addr;
      rf_wd3_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q  <= 1'b0;
      rf_a3_q  <= 5'd0;
      rf_wd3_q <= 32'd0;
    end else begin
      rf_we_q  <= rf_we_d;
      rf_a3_q  <= rf_a3_d;
      rf_wd3_q <= rf_wd3_d;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_a3      = rf_a3_q;
  assign bus.rf_wd3     = rf_wd3_q;
  assign bus.pend_mask  = rf_we_q ? (32'd1 << rf_a3_q) : 32'd0;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a small register-file model.
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] rfm [32] = '{default: 32'd0};
  logic [5:0]  gseq;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(.AGE_LIMIT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.rf_we) rfm[bus.rf_a3] <= bus.rf_wd3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state, with a requester asking during reset
    drive(1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
    #12;
    chk("rst_we", bus.rf_we, 0);
    chk("rst_a3", bus.rf_a3, 0);
    chk("rst_wd3", bus.rf_wd3, 0);
    chk("rst_pend", bus.pend_mask, 0);
    chk("rst_rdy0", bus.req0_ready, 0);
    chk("rst_rdy1", bus.req1_ready, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("idle_rdy0", bus.req0_ready, 0);
    chk("idle_rdy1", bus.req1_ready, 0);

    // Single req0 write
    drive(1, 5'd3, 32'hDEADBEEF, 0, 0, 0);
    #1;
    chk("s0_rdy0", bus.req0_ready, 1);
    chk("s0_rdy1", bus.req1_ready, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("s0_we", bus.rf_we, 1);
    chk("s0_a3", bus.rf_a3, 3);
    chk("s0_wd3", bus.rf_wd3, 32'hDEADBEEF);
    chk("s0_pend", bus.pend_mask, 32'h8);
    tick();
    chk("s0_idle_we", bus.rf_we, 0);
    chk("s0_hold_a3", bus.rf_a3, 3);
    chk("s0_rf3", rfm[3], 32'hDEADBEEF);

    // req1 write to x0: accepted, dropped
    drive(0, 0, 0, 1, 5'd0, 32'h1234);
    #1;
    chk("x0_rdy1", bus.req1_ready, 1);
    chk("x0_rdy0", bus.req0_ready, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("x0_we", bus.rf_we, 0);
    chk("x0_pend", bus.pend_mask, 0);
    chk("x0_hold_a3", bus.rf_a3, 3);
    chk("x0_hold_wd3", bus.rf_wd3, 32'hDEADBEEF);

    // Single req1 write
    drive(0, 0, 0, 1, 5'd9, 32'h99);
    #1;
    chk("s1_rdy1", bus.req1_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("s1_a3", bus.rf_a3, 9);
    chk("s1_wd3", bus.rf_wd3, 32'h99);
    chk("s1_pend", bus.pend_mask, 32'h200);

    // Continuous contention from reset; bit i = 1 means req1 granted
`ifdef WB_ARB_RR_EN
    gseq = 6'b101010;
`else
    gseq = 6'b010000;
`endif
    tick();
    do_reset();
    drive(1, 5'd1, 32'h100, 1, 5'd2, 32'h200);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("arb%0d_rdy0", i), bus.req0_ready, !gseq[i]);
      chk($sformatf("arb%0d_rdy1", i), bus.req1_ready, gseq[i]);
      tick();
      chk($sformatf("arb%0d_a3", i), bus.rf_a3, gseq[i] ? 32'd2 : 32'd1);
    end
    drive(0, 0, 0, 0, 0, 0);

    // Same-address collision from reset: req0 first, then req1, last wins
    tick();
    do_reset();
    drive(1, 5'd7, 32'hA, 1, 5'd7, 32'hB);
    #1;
    chk("col_rdy0", bus.req0_ready, 1);
    tick();
    drive(0, 0, 0, 1, 5'd7, 32'hB);
    chk("col_wd3_a", bus.rf_wd3, 32'hA);
    #1;
    chk("col_rdy1", bus.req1_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("col_wd3_b", bus.rf_wd3, 32'hB);
    tick();
    chk("col_rf7", rfm[7], 32'hB);

    // Reset mid-write: registered write to x5 is dropped
    drive(1, 5'd5, 32'h55, 0, 0, 0);
    #1;
    chk("mr_rdy0", bus.req0_ready, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_we", bus.rf_we, 0);
    chk("mr_pend", bus.pend_mask, 0);
    chk("mr_rdy0_rst", bus.req0_ready, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1, 5'd4, 32'h44, 0, 0, 0);
    #1;
    chk("mr_first_rdy0", bus.req0_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("mr_first_a3", bus.rf_a3, 4);
    tick();
    chk("mr_rf5", rfm[5], 0);
    chk("mr_rf4", rfm[4], 32'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
